// File: rtl/timer_sched_pkg.sv
// Shared types and APB register map for the timer scheduler.
// Optional watchdog is enabled by defining TIMER_SCHED_WATCHDOG_EN.
package timer_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OVF_SETUP,
        OVF_ACCESS,
        EN_SETUP,
        EN_ACCESS,
        WAIT_INT,
        DIS_SETUP,
        DIS_ACCESS
    } state_t;

    localparam logic [7:0]  TMR_OVF_ADDR = 8'h00;
    localparam logic [7:0]  TMR_VAL_ADDR = 8'h04;
    localparam logic [7:0]  TMR_CTL_ADDR = 8'h08;
    localparam logic [31:0] CTL_EN       = 32'h0000_0001;
    localparam logic [31:0] CTL_DIS      = 32'h0000_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search begins one past the last granted index.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    int w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = PW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one APB timer among NREQ requesters, one timed period at a time.
// Define TIMER_SCHED_WATCHDOG_EN to add the WAIT_INT watchdog and wd_err.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int WD_SLACK = 16
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_period,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   early,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PADDR,
    output logic [31:0]       PWDATA,
    input  logic              PREADY,
    input  logic              GPIO_INT,
    input  logic              FIRE_INT
`ifdef TIMER_SCHED_WATCHDOG_EN
    ,
    output logic              wd_err
`endif
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WD_SLACK < 0) begin : g_cfg_err
        $error("timer_scheduler: NREQ must be 2..8, WD_SLACK >= 0");
    end

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_ptr;
    logic [31:0]       r_period;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   r_early;
    logic              r_armed;

    logic [NREQ-1:0]   w_arb_oh;
    logic [PW-1:0]     w_arb_idx;
    logic              w_arb_any;
    logic              w_take;
    logic [NREQ-1:0]   w_grant_oh;
    logic              w_wd_hit;
    logic [31:0]       w_per [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_per
        assign w_per[i] = req_period[i*32 +: 32];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_oh),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // r_armed holds off the first grant until one edge after reset release
    assign w_take     = (r_state == IDLE) && w_arb_any && r_armed;
    assign w_grant_oh = NREQ'(1) << r_ptr;

`ifdef TIMER_SCHED_WATCHDOG_EN
    logic [31:0] r_wd_cnt;
    logic        r_wd_err;
    logic [32:0] w_wd_lim;

    assign w_wd_lim = {1'b0, r_period} + 33'(WD_SLACK);
    assign w_wd_hit = (r_state == WAIT_INT)
                   && (({1'b0, r_wd_cnt} + 33'd1) >= w_wd_lim);
    assign wd_err   = r_wd_err;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_wd_cnt <= '0;
            r_wd_err <= 1'b0;
        end else begin
            r_wd_cnt <= (r_state == WAIT_INT) ? r_wd_cnt + 32'd1 : '0;
            r_wd_err <= w_wd_hit && !GPIO_INT;
        end
    end
`else
    assign w_wd_hit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:       if (w_take) w_next = OVF_SETUP;
            OVF_SETUP:  w_next = OVF_ACCESS;
            OVF_ACCESS: if (PREADY) w_next = EN_SETUP;
            EN_SETUP:   w_next = EN_ACCESS;
            EN_ACCESS:  if (PREADY) w_next = WAIT_INT;
            WAIT_INT:   if (GPIO_INT || w_wd_hit) w_next = DIS_SETUP;
            DIS_SETUP:  w_next = DIS_ACCESS;
            DIS_ACCESS: if (PREADY) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 8'h00;
        PWDATA  = '0;
        unique case (r_state)
            OVF_SETUP, OVF_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (r_state == OVF_ACCESS);
                PWRITE  = 1'b1;
                PADDR   = TMR_OVF_ADDR;
                PWDATA  = r_period;
            end
            EN_SETUP, EN_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (r_state == EN_ACCESS);
                PWRITE  = 1'b1;
                PADDR   = TMR_CTL_ADDR;
                PWDATA  = CTL_EN;
            end
            DIS_SETUP, DIS_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (r_state == DIS_ACCESS);
                PWRITE  = 1'b1;
                PADDR   = TMR_CTL_ADDR;
                PWDATA  = CTL_DIS;
            end
            default: begin
                PSEL    = 1'b0;
            end
        endcase
    end

    assign req_ready = (r_state == OVF_SETUP) ? w_grant_oh : '0;
    assign done      = r_done;
    assign early     = r_early;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state  <= IDLE;
            r_ptr    <= PW'(NREQ - 1);
            r_period <= '0;
            r_done   <= '0;
            r_early  <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            if (w_take) begin
                r_ptr    <= w_arb_idx;
                r_period <= w_per[w_arb_idx];
            end
            r_done  <= (r_state == WAIT_INT && GPIO_INT) ? w_grant_oh : '0;
            r_early <= (r_state == WAIT_INT && FIRE_INT) ? w_grant_oh : '0;
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Randomized bench for timer_scheduler against a transaction-level model.
// Watchdog checks are included when TIMER_SCHED_WATCHDOG_EN is defined.
module tb_timer_scheduler;

    localparam int N = 2;

    logic            PCLK = 1'b0;
    logic            PRESETN = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_period = '0;
    logic [N-1:0]    req_ready, done, early;
    logic            busy, PSEL, PENABLE, PWRITE;
    logic [7:0]      PADDR;
    logic [31:0]     PWDATA;
    logic            PREADY = 1'b1;
    logic            GPIO_INT = 1'b0;
    logic            FIRE_INT = 1'b0;
`ifdef TIMER_SCHED_WATCHDOG_EN
    logic            wd_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int last  = N - 1;

    timer_scheduler #(.NREQ(N), .WD_SLACK(16)) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .req_valid  (req_valid),
        .req_period (req_period),
        .req_ready  (req_ready),
        .done       (done),
        .early      (early),
        .busy       (busy),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .GPIO_INT   (GPIO_INT),
        .FIRE_INT   (FIRE_INT)
`ifdef TIMER_SCHED_WATCHDOG_EN
        ,
        .wd_err     (wd_err)
`endif
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int from);
        for (int k = 1; k <= N; k++)
            if (v[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] rnd_period();
        return ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    endfunction

    task automatic chk_bus(input string tag, input logic s, input logic e,
                           input logic [7:0] a, input logic [31:0] d);
        check({tag, ".psel"}, PSEL, s);
        check({tag, ".penable"}, PENABLE, e);
        check({tag, ".pwrite"}, PWRITE, s);
        check({tag, ".paddr"}, PADDR, a);
        check({tag, ".pwdata"}, PWDATA, d);
    endtask

    task automatic chk_zero(input string tag);
        chk_bus(tag, 1'b0, 1'b0, 8'h00, 32'h0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".ready"}, req_ready, '0);
        check({tag, ".done"}, done, '0);
        check({tag, ".early"}, early, '0);
    endtask

    // Entered at the SETUP negedge; returns at the negedge of the final
    // ACCESS cycle with PREADY=1 already driven.
    task automatic apb_access(input string tag, input logic [7:0] a,
                              input logic [31:0] d);
        int nw;
        nw = $urandom_range(0, 3);
        for (int w = 0; w <= nw; w++) begin
            @(negedge PCLK);
            chk_bus({tag, ".acc"}, 1'b1, 1'b1, a, d);
            check({tag, ".acc.done"}, done, '0);
            check({tag, ".acc.early"}, early, '0);
            PREADY = (w == nw);
        end
    endtask

    // Called at an IDLE negedge; runs through enable-write completion.
    task automatic start_txn(input logic [N-1:0] v, input bit drop,
                             output logic [N-1:0] oh);
        int g;
        logic [31:0] per;
        GPIO_INT = 1'b0;
        FIRE_INT = 1'b0;
        for (int i = 0; i < N; i++) req_period[i*32 +: 32] = rnd_period();
        g   = pick(v, last);
        oh  = N'(1) << g;
        per = req_period[g*32 +: 32];
        req_valid = v;
        @(negedge PCLK);
        check("ovf_setup.grant", req_ready, oh);
        check("ovf_setup.busy", busy, 1'b1);
        chk_bus("ovf_setup", 1'b1, 1'b0, 8'h00, per);
        last = g;
        for (int i = 0; i < N; i++) req_period[i*32 +: 32] = $urandom;
        if (drop) req_valid = '0;
        apb_access("ovf", 8'h00, per);
        @(negedge PCLK);
        chk_bus("en_setup", 1'b1, 1'b0, 8'h08, 32'h1);
        check("en_setup.ready", req_ready, '0);
        apb_access("en", 8'h08, 32'h1);
    endtask

    task automatic run_txn(input logic [N-1:0] v, input bit drop);
        logic [N-1:0] oh;
        int  L, f;
        bit  prev_fire;
        start_txn(v, drop, oh);
        L = $urandom_range(1, 12);
        f = $urandom_range(0, L + 3);
        prev_fire = 1'b0;
        for (int c = 0; c <= L; c++) begin
            @(negedge PCLK);
            check("wait.psel", PSEL, 1'b0);
            check("wait.busy", busy, 1'b1);
            check("wait.early", early, prev_fire ? oh : '0);
            check("wait.done", done, '0);
            FIRE_INT  = (c == f);
            GPIO_INT  = (c == L);
            prev_fire = (c == f);
        end
        @(negedge PCLK);
        check("dis_setup.done", done, oh);
        check("dis_setup.early", early, prev_fire ? oh : '0);
`ifdef TIMER_SCHED_WATCHDOG_EN
        check("dis_setup.wd_err", wd_err, 1'b0);
`endif
        chk_bus("dis_setup", 1'b1, 1'b0, 8'h08, 32'h0);
        GPIO_INT = 1'($urandom);
        FIRE_INT = 1'($urandom);
        apb_access("dis", 8'h08, 32'h0);
        @(negedge PCLK);
        chk_zero("idle_after");
    endtask

    task automatic idle_gap(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) begin
            GPIO_INT = 1'($urandom);
            FIRE_INT = 1'($urandom);
            @(negedge PCLK);
            chk_zero("idle_gap");
        end
        GPIO_INT = 1'b0;
        FIRE_INT = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] oh;
        #2;
        chk_zero("reset");
        req_valid = 2'b11;
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESETN = 1'b1;
        @(negedge PCLK);
        check("first_edge.ready", req_ready, '0);
        check("first_edge.busy", busy, 1'b0);
        req_valid = '0;
        @(negedge PCLK);
        chk_zero("post_reset_idle");

        for (int i = 0; i < 4; i++) run_txn(2'b11, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
            run_txn(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom));
        end

        GPIO_INT  = 1'b0;
        FIRE_INT  = 1'b0;
        req_period[31:0] = 32'd10;
        req_valid = 2'b11;
        oh = N'(1) << pick(2'b11, last);
        @(negedge PCLK);
        check("mid.grant", req_ready, oh);
        last = pick(2'b11, last);
        PREADY = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        chk_bus("mid.en_setup", 1'b1, 1'b0, 8'h08, 32'h1);
        PREADY = 1'b0;
        @(negedge PCLK);
        chk_bus("mid.en_access", 1'b1, 1'b1, 8'h08, 32'h1);
        #2 PRESETN = 1'b0;
        #1 chk_zero("mid_reset");
        last = N - 1;
        req_valid = '0;
        @(negedge PCLK);
        chk_zero("mid_reset_held");
        #2 PRESETN = 1'b1;
        PREADY = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        run_txn(2'b11, 1'b0);
        run_txn(2'b10, 1'b1);
        idle_gap(3);

`ifdef TIMER_SCHED_WATCHDOG_EN
        req_period = {32'd4, 32'd4};
        start_txn(2'b01, 1'b1, oh);
        for (int i = 0; i < N; i++) req_period[i*32 +: 32] = 32'd4;
        for (int c = 0; c < 20; c++) begin
            @(negedge PCLK);
            check("wd.wait.busy", busy, 1'b1);
            check("wd.wait.err", wd_err, 1'b0);
        end
        @(negedge PCLK);
        check("wd.err", wd_err, 1'b1);
        check("wd.done", done, '0);
        chk_bus("wd.dis_setup", 1'b1, 1'b0, 8'h08, 32'h0);
        apb_access("wd.dis", 8'h08, 32'h0);
        @(negedge PCLK);
        chk_zero("wd.idle");
        check("wd.err_clear", wd_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing one timer (range 2..8).
REQ-002 Parameter WD_SLACK, default 16, watchdog margin in cycles (used only with the Configuration macro).
REQ-003 PCLK  in  1  sole clock; all logic on rising edge.
REQ-004 PRESETN  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NREQ  per-requester request for one timed period.
REQ-006 req_period  in  NREQ*32  per-requester overflow value; slice i belongs to requester i.
REQ-007 req_ready  out  NREQ  one-hot, one-cycle grant pulse.
REQ-008 done  out  NREQ  one-hot, one-cycle pulse when the granted period expires.
REQ-009 early  out  NREQ  one-hot, one-cycle pulse forwarding the timer's 1/8-period event.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 PSEL, PENABLE, PWRITE  out  1 each; PADDR  out  8; PWDATA  out  32  APB master to the timer.
REQ-012 PREADY  in  1  APB ready from the timer.
REQ-013 GPIO_INT  in  1  timer overflow pulse; FIRE_INT  in  1  timer 1/8-period pulse.

Function
REQ-014 The FSM SHALL have states IDLE, OVF_SETUP, OVF_ACCESS, EN_SETUP, EN_ACCESS, WAIT_INT, DIS_SETUP, DIS_ACCESS.
REQ-015 IDLE with any req_valid bit set SHALL go to OVF_SETUP on the next edge, latching the grant index and req_period[grant].
REQ-016 Arbitration SHALL be round-robin: search starts at last granted index + 1, wrapping at NREQ-1 -> 0; after reset, requester 0 has highest priority.
REQ-017 req_ready[grant] SHALL be high for exactly the OVF_SETUP cycle.
REQ-018 SETUP states SHALL drive PSEL=1, PENABLE=0, PWRITE=1; ACCESS states PSEL=1, PENABLE=1, PWRITE=1; all other states PSEL=PENABLE=PWRITE=0.
REQ-019 PADDR/PWDATA SHALL hold constant through SETUP and ACCESS: OVF -> 0x00/latched period; EN -> 0x08/0x00000001; DIS -> 0x08/0x00000000.
REQ-020 Each ACCESS state SHALL be held until PREADY=1, then advance (OVF_ACCESS->EN_SETUP, EN_ACCESS->WAIT_INT, DIS_ACCESS->IDLE).
REQ-021 In WAIT_INT, FIRE_INT=1 SHALL produce early[grant]=1 on the next cycle; GPIO_INT=1 SHALL go to DIS_SETUP and produce done[grant]=1 on the next cycle.
REQ-022 GPIO_INT and FIRE_INT outside WAIT_INT SHALL be ignored; simultaneous assertion in WAIT_INT SHALL produce both pulses.
REQ-023 req_period=0 SHALL be passed unmodified (the timer then overflows within 2 cycles).
REQ-024 req_valid deasserted after grant SHALL NOT abort the sequence; a requester needing another period re-requests.
REQ-025 Minimum request-to-grant latency SHALL be 1 cycle; with PREADY tied high, done follows enable write completion after period+2 cycles.

Reset
REQ-026 PRESETN low SHALL immediately force state=IDLE, grant pointer=NREQ-1, and all outputs to 0 (PADDR=0x00, PWDATA=0), including mid-APB transfer.
REQ-027 After PRESETN release, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-028 Macro TIMER_SCHED_WATCHDOG_EN defined: a 32-bit cycle counter SHALL run in WAIT_INT; reaching period+WD_SLACK without GPIO_INT SHALL go to DIS_SETUP and pulse output wd_err (1 bit) instead of done.
REQ-029 Macro undefined: no watchdog counter and no wd_err port; WAIT_INT waits indefinitely.

Structure
REQ-030 Package timer_sched_pkg SHALL hold the state enum, TMR_OVF_ADDR=8'h00, TMR_VAL_ADDR=8'h04, TMR_CTL_ADDR=8'h08, CTL_EN=32'h1.
REQ-031 Round-robin arbitration SHALL be a separate sub-module rr_arbiter (request vector, pointer in; one-hot grant out).

Verification
REQ-032 req_valid=2'b01, period=10, PREADY=1 -> writes 0x00<=10, 0x08<=1; GPIO_INT after 11 timer cycles -> done=2'b01, then write 0x08<=0, busy drops.
REQ-033 req_valid=2'b11 held continuously -> grants alternate 01,10,01,10.
REQ-034 PREADY low for 3 cycles in OVF_ACCESS -> PSEL/PENABLE/PADDR/PWDATA held constant 3 extra cycles, single write.
REQ-035 PRESETN asserted during EN_ACCESS -> all outputs 0 same cycle; after release, req_valid=2'b10 -> requester 1 granted.
REQ-036 FIRE_INT at cycle 2 and GPIO_INT at cycle 11 of WAIT_INT, period=10 -> early pulse then done pulse for the granted requester; spurious GPIO_INT in IDLE -> no pulse.
REQ-037 With TIMER_SCHED_WATCHDOG_EN, period=4, GPIO_INT never asserted -> wd_err pulse after 20 cycles in WAIT_INT, disable write, no done.
